// File: rtl/hazard_stall_if.sv
// hazard_stall_if: ID/EX hazard inputs and front-end stall/flush controls
interface hazard_stall_if #(parameter int CNT_W = 16);
  logic [3:0] id_op1;
  logic [3:0] id_op2;
  logic id_use1;
  logic id_use2;
  logic id_is_md;
  logic id_branch_taken;
  logic ex_memread;
  logic [3:0] ex_op2;
  logic pc_we;
  logic ifid_we;
  logic idex_bubble;
  logic ifid_flush;
  logic md_busy;
  logic md_done;
  logic [CNT_W-1:0] stall_count;
  modport master (
    output id_op1, id_op2, id_use1, id_use2, id_is_md, id_branch_taken, ex_memread, ex_op2,
    input pc_we, ifid_we, idex_bubble, ifid_flush, md_busy, md_done, stall_count
  );
  modport slave (
    input id_op1, id_op2, id_use1, id_use2, id_is_md, id_branch_taken, ex_memread, ex_op2,
    output pc_we, ifid_we, idex_bubble, ifid_flush, md_busy, md_done, stall_count
  );
endinterface

// File: rtl/hazard_stall_unit.sv
// hazard_stall_unit: load-use and R0/multiply-divide stall control with branch flush
module hazard_stall_unit #(
  parameter int MD_CYCLES = 4,
  parameter int CNT_W = 16
) (
  input logic clk,
  input logic rst,
  hazard_stall_if.slave bus
);
  typedef enum logic {RUN, MD_BUSY} state_t;
  state_t state;
  logic [3:0] md_cnt;
  logic [CNT_W-1:0] stall_cnt;
  logic busy;
  logic done;
  logic rd1;
  logic rd2;
  logic load_hz;
  logic md_hz;
  logic stall;
  always_comb begin
    rd1 = bus.id_use1 && bus.id_op1 == 4'd0;
    rd2 = bus.id_use2 && bus.id_op2 == 4'd0;
    load_hz = bus.ex_memread && bus.ex_op2 != 4'd0 &&
              ((bus.id_use1 && bus.id_op1 == bus.ex_op2) || (bus.id_use2 && bus.id_op2 == bus.ex_op2));
    md_hz = busy && (rd1 || rd2 || bus.id_is_md);
    stall = load_hz || md_hz;
  end
  assign bus.pc_we = !stall;
  assign bus.ifid_we = !stall;
  assign bus.idex_bubble = stall;
  assign bus.ifid_flush = bus.id_branch_taken && !stall;
  assign bus.md_busy = busy;
  assign bus.md_done = done;
  assign bus.stall_count = stall_cnt;
  // busy/done are registered alongside the state so they never glitch
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
      md_cnt <= 4'd0;
      busy <= 1'b0;
      done <= 1'b0;
      stall_cnt <= '0;
    end else begin
      if (stall && stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
      done <= 1'b0;
      if (state == RUN) begin
        if (bus.id_is_md && !stall) begin
          state <= MD_BUSY;
          md_cnt <= 4'(MD_CYCLES - 1);
          busy <= 1'b1;
        end
      end else if (md_cnt == 4'd0) begin
        state <= RUN;
        busy <= 1'b0;
      end else begin
        md_cnt <= md_cnt - 4'd1;
        done <= md_cnt == 4'd1;
      end
    end
  end
endmodule

// File: tb/tb_hazard_stall_unit.sv
// tb_hazard_stall_unit: directed and random checks against a cycle-count reference model
module tb_hazard_stall_unit;
  localparam int MDC = 4;
  logic clk = 1'b0;
  logic rst;
  logic [3:0] op1, op2, exop2;
  logic u1, u2, md, br, mr;
  int md_left, sc16, sc4;
  int checks = 0;
  int passes = 0;
  always #5 clk = ~clk;
  hazard_stall_if #(.CNT_W(16)) b16();
  hazard_stall_if #(.CNT_W(4)) b4();
  hazard_stall_unit #(.MD_CYCLES(MDC), .CNT_W(16)) dut16 (.clk(clk), .rst(rst), .bus(b16.slave));
  hazard_stall_unit #(.MD_CYCLES(MDC), .CNT_W(4)) dut4 (.clk(clk), .rst(rst), .bus(b4.slave));
  assign b16.id_op1 = op1;
  assign b16.id_op2 = op2;
  assign b16.id_use1 = u1;
  assign b16.id_use2 = u2;
  assign b16.id_is_md = md;
  assign b16.id_branch_taken = br;
  assign b16.ex_memread = mr;
  assign b16.ex_op2 = exop2;
  assign b4.id_op1 = op1;
  assign b4.id_op2 = op2;
  assign b4.id_use1 = u1;
  assign b4.id_use2 = u2;
  assign b4.id_is_md = md;
  assign b4.id_branch_taken = br;
  assign b4.ex_memread = mr;
  assign b4.ex_op2 = exop2;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
  endtask
  task automatic step();
    bit busy, lh, st;
    @(negedge clk);
    busy = md_left > 0;
    lh = mr && exop2 != 0 && ((u1 && op1 == exop2) || (u2 && op2 == exop2));
    st = lh || (busy && ((u1 && op1 == 0) || (u2 && op2 == 0) || md));
    chk("pc_we", 32'(b16.pc_we), 32'(!st));
    chk("ifid_we", 32'(b16.ifid_we), 32'(!st));
    chk("idex_bubble", 32'(b16.idex_bubble), 32'(st));
    chk("ifid_flush", 32'(b16.ifid_flush), 32'(br && !st));
    chk("md_busy", 32'(b16.md_busy), 32'(busy));
    chk("md_done", 32'(b16.md_done), 32'(md_left == 1));
    chk("stall_count16", 32'(b16.stall_count), 32'(sc16));
    chk("stall_count4", 32'(b4.stall_count), 32'(sc4));
    chk("md_busy4", 32'(b4.md_busy), 32'(busy));
    @(posedge clk);
    if (rst) begin
      md_left = 0;
      sc16 = 0;
      sc4 = 0;
    end else begin
      if (st) begin
        sc16 = sc16 < 65535 ? sc16 + 1 : sc16;
        sc4 = sc4 < 15 ? sc4 + 1 : sc4;
      end
      if (md_left > 0) md_left--;
      else if (md && !st) md_left = MDC;
    end
    #1;
  endtask
  task automatic cyc(input logic [3:0] a, input logic [3:0] b, input logic ua, input logic ub,
                     input logic m, input logic bt, input logic lr, input logic [3:0] e, input logic r);
    op1 = a; op2 = b; u1 = ua; u2 = ub; md = m; br = bt; mr = lr; exop2 = e; rst = r;
    step();
  endtask
  initial begin
    rst = 1'b1;
    {op1, op2, exop2, u1, u2, md, br, mr} = '0;
    @(posedge clk);
    #1;
    md_left = 0; sc16 = 0; sc4 = 0;
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(5, 0, 1, 0, 0, 0, 1, 5, 0);
    cyc(5, 0, 0, 0, 0, 0, 1, 5, 0);
    cyc(0, 0, 0, 0, 1, 0, 0, 0, 0);
    repeat (5) cyc(0, 0, 0, 1, 0, 0, 0, 0, 0);
    cyc(5, 0, 1, 0, 0, 1, 1, 5, 0);
    cyc(5, 0, 1, 0, 0, 1, 0, 0, 0);
    cyc(0, 0, 0, 0, 1, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 1);
    repeat (2) cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 1, 0, 0, 0, 1, 0, 0);
    cyc(0, 0, 0, 0, 1, 0, 0, 0, 0);
    repeat (5) cyc(0, 0, 0, 0, 1, 0, 0, 0, 0);
    repeat (4) cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (20) cyc(5, 0, 1, 0, 0, 0, 1, 5, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (400)
      cyc(4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
          1'($urandom_range(0, 1)), $urandom_range(0, 5) == 0, 1'($urandom_range(0, 1)),
          1'($urandom_range(0, 1)), 4'($urandom_range(0, 3)), $urandom_range(0, 39) == 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/hazard_stall_unit.md
Name: hazard_stall_unit

Overview:
- Pipeline hazard controller that decides when the front end must hold or discard instructions.
- It is the producer of stall/flush control; the forwarding unit is the consumer that resolves operands once hazards have cleared.
- Sits beside the ID stage. Detects load-use hazards and R0 dependencies on the multi-cycle multiply/divide unit, which writes R0 implicitly.
- Drives PC/IF-ID write enables, the ID-EX bubble and the IF-ID flush on taken branches, and tracks multiply/divide busy time with an internal counter.

Parameters:
- MD_CYCLES, 4, execution cycles of a multiply/divide (legal range 2..15).
- CNT_W, 16, width of the saturating stall performance counter.

Ports:
- clk  input  1  system clock, all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- id_op1  input  4  ID-stage source register 1
- id_op2  input  4  ID-stage source register 2
- id_use1  input  1  ID instruction actually reads id_op1
- id_use2  input  1  ID instruction actually reads id_op2
- id_is_md  input  1  ID instruction is multiply/divide (result to R0)
- id_branch_taken  input  1  ID compare resolved a taken branch
- ex_memread  input  1  EX-stage instruction is a load
- ex_op2  input  4  EX-stage destination register
- pc_we  output  1  PC write enable
- ifid_we  output  1  IF/ID register write enable
- idex_bubble  output  1  insert NOP into ID/EX
- ifid_flush  output  1  clear IF/ID (taken branch)
- md_busy  output  1  multiply/divide in progress
- md_done  output  1  one-cycle pulse on multiply/divide completion
- stall_count  output  CNT_W  saturating count of stalled cycles

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- Reset values: state=RUN, md counter=0, md_busy=0, md_done=0, stall_count=0. The combinational outputs settle to pc_we=1, ifid_we=1, idex_bubble=0, ifid_flush=0 when no hazard is present.
- rd1 = id_use1 && id_op1 == 0; rd2 = id_use2 && id_op2 == 0 (R0 consumers).
- load_hz = ex_memread && ex_op2 != 0 && ((id_use1 && id_op1 == ex_op2) || (id_use2 && id_op2 == ex_op2)). Combinational; clears naturally after one bubble.
- md_hz = md_busy && (rd1 || rd2 || id_is_md).
- stall = load_hz || md_hz. When stall is 1: pc_we=0, ifid_we=0, idex_bubble=1, ifid_flush=0.
- Priority: md_hz = load_hz (both stall identically) > branch flush. While stalled, a taken branch is ignored; it is re-evaluated when the stall clears.
- ifid_flush = id_branch_taken && !stall. pc_we and ifid_we stay 1 during a flush.
- FSM states: RUN, MD_BUSY.
  - RUN -> MD_BUSY when id_is_md && !stall; counter loads MD_CYCLES-1.
  - MD_BUSY: counter decrements each cycle. At counter == 0: md_done=1 for that cycle, md_busy drops next cycle, return to RUN.
  - md_busy=1 exactly while state == MD_BUSY. A new id_is_md in the done cycle still stalls; it is accepted the following cycle.
  - MD issue latency: an R0 consumer immediately behind a multiply/divide is stalled MD_CYCLES cycles.
- stall_count increments by 1 on every cycle with stall == 1 and saturates at all-ones (no wrap).
- rst asserted mid-multiply: next edge forces RUN, counter 0, md_busy 0, and no md_done pulse.
- R0 as a load destination never raises load_hz (ex_op2 != 0 guard). R0 hazards come only from multiply/divide.

Test Plan:
- Load-use: ex_memread=1, ex_op2=5, id_op1=5, id_use1=1 -> one cycle pc_we=0, ifid_we=0, idex_bubble=1, stall_count 0->1. Same with id_use1=0 -> no stall.
- MD chain (MD_CYCLES=4): id_is_md=1 at cycle 0, id_op2=0/id_use2=1 held from cycle 1 -> md_busy cycles 1-4, md_done pulse at cycle 4, stall cycles 1-4, stall_count=4.
- Branch vs stall: id_branch_taken=1 together with load_hz=1 -> ifid_flush=0 and stall asserted. Next cycle, branch still taken with no hazard -> ifid_flush=1, pc_we=1.
- Reset mid-op: rst at cycle 2 of a multiply/divide -> next cycle md_busy=0, no md_done, stall_count=0, pc_we=1.
- Saturation: CNT_W=4 with 20 consecutive stall cycles -> stall_count holds 15.
- R0 load guard: ex_memread=1, ex_op2=0, id_op1=0, id_use1=1, md idle -> no stall.
